// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and packet-framing helpers for the UART result packer.
// The packet layout lives here so the framing rules are in one place.
package uart_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         PKT_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT
   } packer_state_t;

   // Checksum covers bytes 1..6: seq, x, y and the padded scale.
   function automatic logic [7:0] packet_chk(
      input logic [7:0]  seq,
      input logic [15:0] x,
      input logic [15:0] y,
      input logic [3:0]  scale
   );
      return seq ^ x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ {4'h0, scale};
   endfunction

   function automatic logic [7:0] packet_byte(
      input logic [2:0]  idx,
      input logic [7:0]  seq,
      input logic [15:0] x,
      input logic [15:0] y,
      input logic [3:0]  scale,
      input logic [7:0]  chk
   );
      logic [7:0] b;
      case (idx)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = seq;
         3'd2:    b = x[15:8];
         3'd3:    b = x[7:0];
         3'd4:    b = y[15:8];
         3'd5:    b = y[7:0];
         3'd6:    b = {4'h0, scale};
         default: b = chk;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO holding detection results; the head entry is always
// visible on pop_data while the FIFO is non-empty.
module result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // A push while full is dropped even if a pop frees a slot this cycle.
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // NOTE: storage is deliberately not reset; the pointers and count define validity,
   // and leaving the array reset-free lets it map onto plain RAM/register files.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_result_packer.sv
// Buffers detection results and frames each as an 8-byte packet, handing bytes one at a
// time to the UART transmitter over a send/sent handshake.
module uart_result_packer
   import uart_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int COORD_W = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               result_valid,
   input  logic [COORD_W-1:0] result_x,
   input  logic [COORD_W-1:0] result_y,
   input  logic [3:0]         result_scale,
   output logic               result_ready,
   output logic [7:0]         uart_data,
   output logic               send_uart_data,
   input  logic               uart_data_sent,
   output logic               busy
);

   localparam int         ENTRY_W  = 2 * COORD_W + 4;
   localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

   packer_state_t      state;
   packer_state_t      next_state;
   logic [ENTRY_W-1:0] head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;

   logic [15:0]        pkt_x;
   logic [15:0]        pkt_y;
   logic [3:0]         pkt_scale;
   logic [7:0]         pkt_chk;
   logic [7:0]         seq;
   logic [2:0]         idx;

   assign result_ready = !fifo_full;
   assign push         = result_valid && result_ready;
   assign pop          = (state == IDLE) && !fifo_empty;
   assign busy         = (state != IDLE) || !fifo_empty;

   result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({result_x, result_y, result_scale}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every output of this block gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      next_state     = state;
      send_uart_data = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            next_state = SEND;
         end
         SEND: begin
            send_uart_data = 1'b1;
            next_state     = WAIT;
         end
         WAIT: begin
            if (uart_data_sent) begin
               next_state = (idx == LAST_IDX) ? IDLE : SEND;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Packet register, byte index and sequence count; sent pulses only matter in WAIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pkt_x     <= '0;
         pkt_y     <= '0;
         pkt_scale <= '0;
         pkt_chk   <= '0;
         idx       <= '0;
         seq       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  pkt_x     <= 16'(head[ENTRY_W-1 -: COORD_W]);
                  pkt_y     <= 16'(head[4 +: COORD_W]);
                  pkt_scale <= head[3:0];
                  idx       <= '0;
               end
            end
            LOAD: begin
               pkt_chk <= packet_chk(seq, pkt_x, pkt_y, pkt_scale);
            end
            WAIT: begin
               if (uart_data_sent) begin
                  if (idx == LAST_IDX) begin
                     seq <= seq + 8'd1;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Pure mux of registers: stable for the whole SEND/WAIT span of each byte.
   assign uart_data = (state == IDLE) ? 8'h00
                    : packet_byte(idx, seq, pkt_x, pkt_y, pkt_scale, pkt_chk);

endmodule

// File: tb/tb_uart_result_packer.sv
// Self-checking bench for uart_result_packer: a transmitter model answers each send pulse,
// and every received byte is compared against packets built from the framing rules.
module tb_uart_result_packer;

   localparam int DEPTH   = 8;
   localparam int COORD_W = 10;

   logic               clock = 1'b0;
   logic               reset;
   logic               result_valid;
   logic [COORD_W-1:0] result_x;
   logic [COORD_W-1:0] result_y;
   logic [3:0]         result_scale;
   logic               result_ready;
   logic [7:0]         uart_data;
   logic               send_uart_data;
   logic               uart_data_sent;
   logic               busy;

   logic               tx_sent;
   logic               spur_sent;
   assign uart_data_sent = tx_sent | spur_sent;

   uart_result_packer #(
      .DEPTH   (DEPTH),
      .COORD_W (COORD_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .result_valid   (result_valid),
      .result_x       (result_x),
      .result_y       (result_y),
      .result_scale   (result_scale),
      .result_ready   (result_ready),
      .uart_data      (uart_data),
      .send_uart_data (send_uart_data),
      .uart_data_sent (uart_data_sent),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transmitter model and byte monitor; sampled on the falling edge.
   int         tx_lat = 20;
   int         tx_cnt;
   bit         in_flight;
   logic [7:0] held;
   int         proto_err;
   logic [7:0] rx_q[$];
   int         pulse_q[$];

   initial begin
      tx_sent   = 1'b0;
      tx_cnt    = 0;
      in_flight = 1'b0;
      held      = 8'h00;
      proto_err = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            tx_sent   = 1'b0;
            tx_cnt    = 0;
            in_flight = 1'b0;
            if (send_uart_data) proto_err++;
         end else begin
            if (tx_sent) in_flight = 1'b0;
            tx_sent = 1'b0;
            if (in_flight && uart_data !== held) proto_err++;
            if (tx_cnt > 0) begin
               tx_cnt--;
               if (tx_cnt == 0) tx_sent = 1'b1;
            end
            if (send_uart_data) begin
               rx_q.push_back(uart_data);
               pulse_q.push_back(cyc);
               held      = uart_data;
               in_flight = 1'b1;
               tx_cnt    = tx_lat;
            end
         end
      end
   end

   // Reference model: expected byte stream in acceptance order.
   logic [7:0] exp_q[$];
   logic [7:0] m_seq;
   int         rx_base;
   int         exp_base;

   task automatic add_expected(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                               input logic [3:0] s);
      logic [7:0]  b [8];
      logic [15:0] xx;
      logic [15:0] yy;
      xx   = 16'(x);
      yy   = 16'(y);
      b[0] = 8'hA5;
      b[1] = m_seq;
      b[2] = xx[15:8];
      b[3] = xx[7:0];
      b[4] = yy[15:8];
      b[5] = yy[7:0];
      b[6] = {4'h0, s};
      b[7] = 8'h00;
      for (int i = 1; i <= 6; i++) b[7] = b[7] ^ b[i];
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      m_seq = m_seq + 8'd1;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sync_bases();
      rx_base  = rx_q.size();
      exp_base = exp_q.size();
      m_seq    = 8'h00;
   endtask

   task automatic offer(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                        input logic [3:0] s, output int acc);
      bit done;
      done         = 1'b0;
      acc          = -1;
      result_valid = 1'b1;
      result_x     = x;
      result_y     = y;
      result_scale = s;
      for (int n = 0; n < 2000 && !done; n++) begin
         if (result_ready === 1'b1) begin
            acc  = cyc;
            done = 1'b1;
            add_expected(x, y, s);
         end
         step();
      end
      result_valid = 1'b0;
      if (!done) check("offer_timeout", 32'(0), 32'(1));
   endtask

   task automatic offer_rand(output int acc);
      offer(COORD_W'($urandom_range(0, (1 << COORD_W) - 1)),
            COORD_W'($urandom_range(0, (1 << COORD_W) - 1)),
            4'($urandom_range(0, 15)), acc);
   endtask

   task automatic wait_bytes(input int n, input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40000 && !ok; k++) begin
         if (rx_q.size() - rx_base >= n) ok = 1'b1;
         else step();
      end
      check({tag, "_arrive"}, 32'(ok), 32'(1));
   endtask

   task automatic wait_stream(input string tag);
      int n;
      n = exp_q.size() - exp_base;
      wait_bytes(n, tag);
      repeat (3 * tx_lat + 12) @(posedge clock);
      #1;
      check({tag, "_count"}, 32'(rx_q.size() - rx_base), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (rx_base + i < rx_q.size())
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]),
                  32'(exp_q[exp_base + i]));
      end
      check({tag, "_idle_busy"}, 32'(busy), 32'(0));
      rx_base  = rx_q.size();
      exp_base = exp_q.size();
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      result_valid = 1'b0;
      spur_sent    = 1'b0;
      step();
      step();
      reset = 1'b0;
      check("deassert_send", 32'(send_uart_data), 32'(0));
      sync_bases();
   endtask

   logic [7:0] t1_exp [8];
   int         acc;
   int         c0;
   int         b;
   int         r;
   bit         seen;

   initial begin
      reset        = 1'b1;
      result_valid = 1'b0;
      result_x     = '0;
      result_y     = '0;
      result_scale = '0;
      spur_sent    = 1'b0;
      m_seq        = 8'h00;
      rx_base      = 0;
      exp_base     = 0;
      step();
      step();
      check("reset_ready", 32'(result_ready), 32'(1));
      check("reset_data", 32'(uart_data), 32'(8'h00));
      check("reset_send", 32'(send_uart_data), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      reset = 1'b0;
      check("deassert_send", 32'(send_uart_data), 32'(0));
      sync_bases();

      // Single directed packet with known bytes.
      tx_lat = 20;
      t1_exp = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h00, 8'h45, 8'h03, 8'h64};
      offer(10'h123, 10'h045, 4'd3, c0);
      wait_bytes(8, "t1");
      check("t1_first_pulse", 32'(pulse_q[rx_base] - c0), 32'(3));
      for (int i = 0; i < 8; i++)
         check($sformatf("t1_const_byte%0d", i), 32'(rx_q[rx_base + i]), 32'(t1_exp[i]));
      for (int i = 0; i < 7; i++)
         check("t1_gap", 32'(pulse_q[rx_base + i + 1] - pulse_q[rx_base + i] > tx_lat), 32'(1));
      wait_stream("t1");

      // Nine pushes against a slow line, then one more held off by back-pressure.
      tx_lat = 60;
      b      = rx_base;
      offer_rand(c0);
      for (int k = 1; k < 9; k++) begin
         offer_rand(acc);
         check("fill_consecutive", 32'(acc - c0), 32'(k));
      end
      check("full_ready", 32'(result_ready), 32'(0));
      check("full_busy", 32'(busy), 32'(1));
      repeat (20) step();
      check("full_hold", 32'(result_ready), 32'(0));
      offer_rand(r);
      wait_stream("t2");
      check("t2_ready_restore", 32'(pulse_q[b + 8] - r), 32'(1));
      check("t2_back_to_back", 32'(pulse_q[b + 8] - pulse_q[b + 7]), 32'(tx_lat + 3));

      // Spurious sent pulses in IDLE and in every SEND cycle.
      tx_lat    = 10;
      spur_sent = 1'b1;
      step();
      spur_sent = 1'b0;
      offer_rand(acc);
      for (int k = 0; k < 8; k++) begin
         seen = 1'b0;
         for (int n = 0; n < 100 && !seen; n++) begin
            if (send_uart_data === 1'b1) seen = 1'b1;
            else step();
         end
         check("spur_send_seen", 32'(seen), 32'(1));
         spur_sent = 1'b1;
         step();
         spur_sent = 1'b0;
      end
      wait_stream("t3");

      // Long run: seq wraps FF -> 00 on the 257th packet.
      do_reset();
      tx_lat = 1;
      b      = rx_base;
      for (int k = 0; k < 260; k++) offer_rand(acc);
      wait_stream("t4");
      check("t4_seq_ff", 32'(rx_q[b + 255 * 8 + 1]), 32'(8'hFF));
      check("t4_seq_wrap", 32'(rx_q[b + 256 * 8 + 1]), 32'(8'h00));

      // Reset during byte 4 with results still queued.
      do_reset();
      tx_lat = 10;
      for (int k = 0; k < 4; k++) offer_rand(acc);
      wait_bytes(5, "t5_pre");
      reset = 1'b1;
      #1;
      check("mid_reset_data", 32'(uart_data), 32'(8'h00));
      check("mid_reset_send", 32'(send_uart_data), 32'(0));
      check("mid_reset_busy", 32'(busy), 32'(0));
      check("mid_reset_ready", 32'(result_ready), 32'(1));
      step();
      step();
      reset = 1'b0;
      check("mid_deassert_send", 32'(send_uart_data), 32'(0));
      step();
      check("mid_after_send", 32'(send_uart_data), 32'(0));
      check("mid_after_busy", 32'(busy), 32'(0));
      sync_bases();
      b = rx_base;
      offer_rand(acc);
      wait_stream("t5");
      check("t5_seq_zero", 32'(rx_q[b + 1]), 32'(8'h00));

      check("protocol", 32'(proto_err), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
